xm_wb_timer: RTL and testbench

- Wishbone responder (slave) peripheral for the xm_cpu data bus. It sits beside mem_wishbone on the same initiator interface and decodes its own address window.
- Provides a 16-bit down-counting timer with a programmable prescaler, one-shot or auto-reload mode, and a sticky expiry flag.
- Gives the CPU a second, register-style responder with side effects on write, for exercising wait-state and byte-lane handling.

---
 rtl/xm_wb_timer_if.sv | 17 +
 rtl/xm_wb_timer.sv | 103 ++++++++++
 tb/tb_xm_wb_timer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xm_wb_timer_if.sv
// Wishbone responder bus bundle for xm_wb_timer.
// Signal names keep the classic _i/_o suffixes as seen from the responder side.
interface xm_wb_timer_if;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic [1:0]  sel_i;
  logic [14:0] adr_i;
  logic [15:0] dat_i;
  logic        ack_o;
  logic [15:0] dat_o;

  modport master (output we_i, stb_i, cyc_i, sel_i, adr_i, dat_i,
                  input  ack_o, dat_o);
  modport slave  (input  we_i, stb_i, cyc_i, sel_i, adr_i, dat_i,
                  output ack_o, dat_o);
endinterface

// File: rtl/xm_wb_timer.sv
// Wishbone 16-bit down-counting timer with prescaler, one-shot/auto-reload, sticky EXP.
// Optional XM_TIMER_IRQ_EN adds CTRL.IE and a registered level interrupt on irq_o.
module xm_wb_timer #(
  parameter logic [14:0] BASE_ADR   = 15'h7FF0,
  parameter logic [15:0] RST_RELOAD = 16'hFFFF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  xm_wb_timer_if.slave bus,
  output logic         irq_o
);
  logic        en, auto_rl, ie, exp;
  logic [7:0]  pre, pre_cnt;
  logic [15:0] count, reload, rd_data;
  logic        hit, accept, wr, tick, expire, bus_wins, restart;
  logic        wr_ctrl, wr_count, wr_reload, clr_exp;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] sel);
    merge = {sel[1] ? d[15:8] : old[15:8], sel[0] ? d[7:0] : old[7:0]};
  endfunction

  assign hit       = bus.adr_i[14:2] == BASE_ADR[14:2];
  assign accept    = bus.cyc_i & bus.stb_i & hit & ~bus.ack_o;
  // sel_i == 0 writes are acked but count as no write at all
  assign wr        = accept & bus.we_i & (|bus.sel_i);
  assign wr_ctrl   = wr & (bus.adr_i[1:0] == 2'd0);
  assign wr_count  = wr & (bus.adr_i[1:0] == 2'd1);
  assign wr_reload = wr & (bus.adr_i[1:0] == 2'd2);
  assign clr_exp   = wr & (bus.adr_i[1:0] == 2'd3) & bus.sel_i[0] & bus.dat_i[0];
  assign restart   = wr_ctrl & bus.sel_i[0] & bus.dat_i[0];

  assign tick      = en & (pre_cnt == pre);
  assign expire    = tick & (count == 16'd0);
  assign bus_wins  = wr_ctrl | wr_count;

  always_comb begin
    rd_data = '0;
    case (bus.adr_i[1:0])
      2'd0: rd_data = {pre, 5'd0, ie, auto_rl, en};
      2'd1: rd_data = count;
      2'd2: rd_data = reload;
      2'd3: rd_data = {15'd0, exp};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      pre       <= '0;
      pre_cnt   <= '0;
      count     <= '0;
      reload    <= RST_RELOAD;
      exp       <= 1'b0;
    end else begin
      bus.ack_o <= accept;
      bus.dat_o <= (accept & ~bus.we_i) ? rd_data : '0;

      if (restart || !en || tick) pre_cnt <= '0;
      else                        pre_cnt <= pre_cnt + 8'd1;

      // A CTRL/COUNT write in a tick cycle wins over the tick's count/EN effect
      if (tick && !bus_wins) begin
        if (count != 16'd0) count <= count - 16'd1;
        else if (auto_rl)   count <= reload;
        else                en    <= 1'b0;
      end

      if (wr_ctrl) begin
        if (bus.sel_i[0]) begin
          en      <= bus.dat_i[0];
          auto_rl <= bus.dat_i[1];
        end
        if (bus.sel_i[1]) pre <= bus.dat_i[15:8];
      end
      if (wr_count)  count  <= merge(count, bus.dat_i, bus.sel_i);
      if (wr_reload) reload <= merge(reload, bus.dat_i, bus.sel_i);

      // set beats clear
      if (expire)       exp <= 1'b1;
      else if (clr_exp) exp <= 1'b0;
    end
  end

`ifdef XM_TIMER_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl && bus.sel_i[0]) ie <= bus.dat_i[2];
      irq_o <= exp & ie;
    end
  end
`else
  assign ie    = 1'b0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_xm_wb_timer.sv
// Self-checking bench for xm_wb_timer: directed test-plan steps plus random bus
// traffic, every cycle compared against a behavioural timer model.
module tb_xm_wb_timer;
  localparam logic [14:0] BASE = 15'h7FF0;

  logic clk_i, rst_i, irq_o;
  xm_wb_timer_if bus();

  xm_wb_timer #(.BASE_ADR(BASE), .RST_RELOAD(16'hFFFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .irq_o(irq_o));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // behavioural model state (post-edge values)
  logic        m_ack, m_irq, m_en, m_auto, m_ie, m_exp;
  logic [15:0] m_dat, m_count, m_reload;
  int          m_pre, m_since;

`ifdef XM_TIMER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_ack = 0; m_dat = 0; m_irq = 0; m_en = 0; m_auto = 0; m_ie = 0;
    m_pre = 0; m_count = 0; m_reload = 16'hFFFF; m_exp = 0; m_since = 0;
  endtask

  function automatic logic [15:0] mdl_rd(input logic [1:0] off);
    case (off)
      2'd0:    return {m_pre[7:0], 5'd0, m_ie, m_auto, m_en};
      2'd1:    return m_count;
      2'd2:    return m_reload;
      default: return {15'd0, m_exp};
    endcase
  endfunction

  // Timer as the rules read: a tick lands every PRE+1 cycles counted from the
  // moment the timer was (re)enabled; bus writes to CTRL/COUNT override it.
  task automatic mdl_edge();
    logic acc, wr, tick, supp;
    logic [1:0] off, s;
    logic [15:0] d, n_count, n_dat;
    logic n_en, n_exp, n_irq, restart;
    if (rst_i) begin mdl_reset(); return; end
    off = bus.adr_i[1:0]; s = bus.sel_i; d = bus.dat_i;
    acc  = bus.cyc_i && bus.stb_i && (bus.adr_i[14:2] == BASE[14:2]) && !m_ack;
    wr   = acc && bus.we_i && (s != 2'b00);
    tick = m_en && ((m_since % (m_pre + 1)) == m_pre);
    supp = wr && (off == 2'd0 || off == 2'd1);
    n_dat = (acc && !bus.we_i) ? mdl_rd(off) : 16'h0;
    n_irq = HAS_IRQ && m_exp && m_ie;
    n_count = m_count; n_en = m_en; n_exp = m_exp; restart = 0;
    if (wr && off == 2'd3 && s[0] && d[0]) n_exp = 0;
    if (tick && m_count == 0) n_exp = 1;
    if (tick && !supp) begin
      if (m_count != 0) n_count = m_count - 1;
      else if (m_auto)  n_count = m_reload;
      else              n_en = 0;
    end
    if (wr && off == 2'd0) begin
      if (s[0]) begin
        n_en = d[0]; m_auto = d[1]; restart = d[0];
        if (HAS_IRQ) m_ie = d[2];
      end
      if (s[1]) m_pre = d[15:8];
    end
    if (wr && off == 2'd1)
      n_count = {s[1] ? d[15:8] : m_count[15:8], s[0] ? d[7:0] : m_count[7:0]};
    if (wr && off == 2'd2)
      m_reload = {s[1] ? d[15:8] : m_reload[15:8], s[0] ? d[7:0] : m_reload[7:0]};
    m_since = (restart || !n_en) ? 0 : m_since + 1;
    m_count = n_count; m_en = n_en; m_exp = n_exp;
    m_ack = acc; m_dat = n_dat; m_irq = n_irq;
  endtask

  task automatic clk1();
    @(posedge clk_i);
    mdl_edge();
    @(negedge clk_i);
    chk("ack", {15'd0, bus.ack_o}, {15'd0, m_ack});
    chk("dat", bus.dat_o, m_dat);
    chk("irq", {15'd0, irq_o}, {15'd0, m_irq});
  endtask

  task automatic idle(input int n);
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    repeat (n) clk1();
  endtask

  task automatic bus_op(input logic w, input logic [1:0] off, input logic [1:0] s,
                        input logic [15:0] d, output logic [15:0] rd);
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = w;
    bus.adr_i = {BASE[14:2], off}; bus.sel_i = s; bus.dat_i = d;
    clk1();
    chk("op_ack", {15'd0, bus.ack_o}, 16'd1);
    rd = bus.dat_o;
    idle(1);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [1:0] s, input logic [15:0] d);
    logic [15:0] rd;
    bus_op(1'b1, off, s, d, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [15:0] exp);
    logic [15:0] rd;
    bus_op(1'b0, off, 2'b11, 16'h0, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ctl, d, rd;
    logic [1:0]  off, s;
    logic        w;
    mdl_reset();
    rst_i = 1; bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    bus.sel_i = 0; bus.adr_i = BASE; bus.dat_i = 0;
    clk1(); clk1();
    rst_i = 0;
    idle(1);

    // reset values
    rd_chk("rst_ctrl", 2'd0, 16'h0000);
    rd_chk("rst_count", 2'd1, 16'h0000);
    rd_chk("rst_reload", 2'd2, 16'hFFFF);
    rd_chk("rst_status", 2'd3, 16'h0000);

    // auto-reload, PRE=0
    wr_reg(2'd2, 2'b11, 16'h0003);
    wr_reg(2'd1, 2'b11, 16'h0003);
    wr_reg(2'd0, 2'b11, 16'h0003);
    idle(9);
    rd_chk("auto_exp", 2'd3, 16'h0001);
    rd_chk("auto_en", 2'd0, 16'h0003);
    wr_reg(2'd0, 2'b11, 16'h0000);
    wr_reg(2'd3, 2'b11, 16'h0001);
    rd_chk("exp_clr", 2'd3, 16'h0000);

    // one-shot, PRE=2: expiry on the 9th edge after the CTRL accept edge
    wr_reg(2'd1, 2'b11, 16'h0002);
    wr_reg(2'd0, 2'b11, 16'h0201);
    idle(5);
    rd_chk("os_early", 2'd3, 16'h0000);
    idle(1);
    rd_chk("os_exp", 2'd3, 16'h0001);
    rd_chk("os_en", 2'd0, 16'h0200);
    rd_chk("os_count", 2'd1, 16'h0000);

    // byte lanes
    wr_reg(2'd2, 2'b11, 16'h1234);
    wr_reg(2'd2, 2'b10, 16'hABCD);
    rd_chk("lane_hi", 2'd2, 16'hAB34);
    wr_reg(2'd2, 2'b00, 16'h5555);
    rd_chk("lane_none", 2'd2, 16'hAB34);

    // W1C racing an expiry, then on a quiet cycle
    wr_reg(2'd3, 2'b11, 16'h0001);
    wr_reg(2'd2, 2'b11, 16'h0003);
    wr_reg(2'd1, 2'b11, 16'h0001);
    ctl = HAS_IRQ ? 16'h0007 : 16'h0003;
    wr_reg(2'd0, 2'b11, ctl);          // accept edge E0; expiries at E2, E6, E10, E14
    idle(4);
    wr_reg(2'd3, 2'b01, 16'h0001);     // E6: set wins
    rd_chk("w1c_race", 2'd3, 16'h0001);
    idle(1);
    if (HAS_IRQ) chk("irq_high", {15'd0, irq_o}, 16'd1);
    wr_reg(2'd3, 2'b01, 16'h0001);     // E11: clears
    if (HAS_IRQ) chk("irq_fall", {15'd0, irq_o}, 16'd0);
    rd_chk("w1c_quiet", 2'd3, 16'h0000);
    rd_chk("ctrl_rd", 2'd0, ctl);
    wr_reg(2'd0, 2'b11, 16'h0000);

    // back-to-back strobe: ack, idle, ack, idle
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = {BASE[14:2], 2'd2};
    for (int i = 0; i < 4; i++) begin
      clk1();
      chk("b2b_ack", {15'd0, bus.ack_o}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    idle(1);

    // address miss
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.sel_i = 2'b11;
    bus.adr_i = BASE + 15'd4; bus.dat_i = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      clk1();
      chk("miss_ack", {15'd0, bus.ack_o}, 16'd0);
    end
    idle(1);
    rd_chk("miss_nochg", 2'd2, 16'h0003);

    // random traffic
    for (int i = 0; i < 250; i++) begin
      off = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      s   = 2'($urandom_range(0, 3));
      d   = 16'($urandom);
      if (off == 2'd0) begin
        s = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
        d[15:8] = 8'($urandom_range(0, 3));
        d[0] = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 2) != 0) begin
        d = 16'($urandom_range(0, 12));
      end
      bus_op(w, off, s, d, rd);
      idle($urandom_range(0, 4));
    end

    // reset one cycle after an accepted read
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = {BASE[14:2], 2'd1};
    clk1();
    bus.cyc_i = 0; bus.stb_i = 0;
    rst_i = 1;
    clk1();
    chk("rst_ack", {15'd0, bus.ack_o}, 16'd0);
    rst_i = 0;
    idle(1);
    rd_chk("rst2_ctrl", 2'd0, 16'h0000);
    rd_chk("rst2_count", 2'd1, 16'h0000);
    rd_chk("rst2_reload", 2'd2, 16'hFFFF);
    rd_chk("rst2_status", 2'd3, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
